// File: rtl/pcu_pkg.sv
// Shared definitions for the program counter unit: mode codes and default widths.
package pcu_pkg;

  localparam int unsigned PCU_MODE_W = 3;
  localparam int unsigned PCU_ADDR_W = 8;

  // Codes 6 and 7 are reserved and decode as HOLD.
  typedef enum logic [PCU_MODE_W-1:0] {
    PCU_HOLD   = 3'd0,
    PCU_INC    = 3'd1,
    PCU_JUMP   = 3'd2,
    PCU_BRANCH = 3'd3,
    PCU_CALL   = 3'd4,
    PCU_RET    = 3'd5
  } pcu_mode_e;

endpackage

// File: rtl/pcu_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry. A pop while empty leaves the state unchanged. Overflow and underflow
// are reported as one-cycle pulses.
module pcu_ras #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAS_DEPTH = 4
)(
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  push_data,
  output logic [ADDR_W-1:0]                  top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     count,
  output logic                               empty,
  output logic                               full,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned CW    = $clog2(RAS_DEPTH+1);
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(RAS_DEPTH-1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_inc, ptr_dec;   // ptr_q is the next free slot
  logic [CW-1:0]     count_q;

  assign ptr_inc = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? LAST : ptr_q - PTR_W'(1);

  assign top   = mem[ptr_dec];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(RAS_DEPTH));

  // Storage is not reset. Clearing the count is enough to discard the contents.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[ptr_q] <= push_data;
  end

  // Update the pointer, the count and the pulse flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q     <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && full;
      underflow <= pop && empty;
      if (push) begin
        ptr_q <= ptr_inc;
        if (!full) count_q <= count_q + CW'(1);
      end else if (pop && !empty) begin
        ptr_q   <= ptr_dec;
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with hold/inc/jump/branch/call/return modes and a return-address stack.
// Define PCU_EXCEPTION_EN to add the exc_req input, the epc_out output and the EXC_VECTOR parameter.
module program_counter_unit
  import pcu_pkg::*;
#(
  parameter int unsigned        ADDR_W       = PCU_ADDR_W,
  parameter int unsigned        RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        INC_STEP     = 1
`ifdef PCU_EXCEPTION_EN
  , parameter logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(8'hF0)
`endif
)(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            pc_write,
  input  logic [PCU_MODE_W-1:0]           mode,
  input  logic [ADDR_W-1:0]               target_in,
  input  logic [ADDR_W-1:0]               offset_in,
`ifdef PCU_EXCEPTION_EN
  input  logic                            exc_req,
  output logic [ADDR_W-1:0]               epc_out,
`endif
  output logic [ADDR_W-1:0]               pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count,
  output logic                            ras_empty,
  output logic                            ras_full,
  output logic                            ras_overflow,
  output logic                            ras_underflow
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC_STEP);

  logic [ADDR_W-1:0] pc_q, pc_nxt, ras_top;
  logic              push, pop;

  assign pc_out = pc_q;

  pcu_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q + STEP),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // Select the next PC from the mode. Offsets are ADDR_W wide, so a plain add is a signed add modulo 2^ADDR_W.
  always_comb begin
    pc_nxt = pc_q;
    push   = 1'b0;
    pop    = 1'b0;
    if (pc_write) begin
      case (mode)
        PCU_INC:    pc_nxt = pc_q + STEP;
        PCU_JUMP:   pc_nxt = target_in;
        PCU_BRANCH: pc_nxt = pc_q + offset_in;
        PCU_CALL: begin
          push   = 1'b1;
          pc_nxt = target_in;
        end
        PCU_RET: begin
          pop    = 1'b1;
          pc_nxt = ras_empty ? pc_q + STEP : ras_top;
        end
        default: ;
      endcase
    end
`ifdef PCU_EXCEPTION_EN
    if (exc_req) begin
      push   = 1'b0;
      pop    = 1'b0;
      pc_nxt = EXC_VECTOR;
    end
`endif
  end

  // PC register.
  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_nxt;
  end

`ifdef PCU_EXCEPTION_EN
  // Save the interrupted PC when an exception is taken.
  always_ff @(posedge clock) begin
    if (reset)        epc_out <= '0;
    else if (exc_req) epc_out <= pc_q;
  end
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed vector table plus a random run checked against a queue-based model.
module tb_program_counter_unit;
  import pcu_pkg::*;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pc_write = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] target_in = 8'h00, offset_in = 8'h00;
  logic [7:0] pc_out;
  logic [2:0] ras_count;
  logic       ras_empty, ras_full, ras_overflow, ras_underflow;
`ifdef PCU_EXCEPTION_EN
  logic       exc_req = 1'b0;
  logic [7:0] epc_out;
  logic [7:0] m_epc;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] m_pc;
  logic [7:0] m_ras[$];
  bit         m_ov, m_un;

  always #5 clock = ~clock;

  program_counter_unit #(.ADDR_W(8), .RAS_DEPTH(DEPTH), .RESET_VECTOR(8'h00), .INC_STEP(1)) dut (
    .clock(clock), .reset(reset), .pc_write(pc_write), .mode(mode),
    .target_in(target_in), .offset_in(offset_in),
`ifdef PCU_EXCEPTION_EN
    .exc_req(exc_req), .epc_out(epc_out),
`endif
    .pc_out(pc_out), .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  typedef struct {
    bit         rst, pw;
    logic [2:0] mode;
    logic [7:0] tgt, off;
    logic [7:0] pc;
    int         cnt;
    bit         ov, un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit pw, logic [2:0] md, logic [7:0] tgt, logic [7:0] off,
                              logic [7:0] pc, int cnt, bit ov, bit un);
    vec_t v;
    v.rst = rst; v.pw = pw; v.mode = md; v.tgt = tgt; v.off = off;
    v.pc = pc; v.cnt = cnt; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model works from the PC value and a LIFO queue, and applies the rules for each mode.
  task automatic model_step(bit rst, bit pw, logic [2:0] md, logic [7:0] tgt, logic [7:0] off, bit exc);
    m_ov = 0; m_un = 0;
    if (rst) begin
      m_pc = 8'h00; m_ras.delete();
`ifdef PCU_EXCEPTION_EN
      m_epc = 8'h00;
`endif
    end else if (exc) begin
`ifdef PCU_EXCEPTION_EN
      m_epc = m_pc;
      m_pc  = 8'hF0;
`endif
    end else if (pw) begin
      case (md)
        3'd1: m_pc = m_pc + 8'd1;
        3'd2: m_pc = tgt;
        3'd3: m_pc = m_pc + off;
        3'd4: begin
          m_ras.push_back(m_pc + 8'd1);
          if (m_ras.size() > DEPTH) begin void'(m_ras.pop_front()); m_ov = 1; end
          m_pc = tgt;
        end
        3'd5: begin
          if (m_ras.size() == 0) begin m_pc = m_pc + 8'd1; m_un = 1; end
          else m_pc = m_ras.pop_back();
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(bit rst, bit pw, logic [2:0] md, logic [7:0] tgt, logic [7:0] off, bit exc);
    reset = rst; pc_write = pw; mode = md; target_in = tgt; offset_in = off;
`ifdef PCU_EXCEPTION_EN
    exc_req = exc;
`endif
    @(posedge clock);
    model_step(rst, pw, md, tgt, off, exc);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".pc"},    pc_out, m_pc);
    chk({tag, ".count"}, ras_count, m_ras.size());
    chk({tag, ".empty"}, ras_empty, m_ras.size() == 0);
    chk({tag, ".full"},  ras_full, m_ras.size() == DEPTH);
    chk({tag, ".ovf"},   ras_overflow, m_ov);
    chk({tag, ".unf"},   ras_underflow, m_un);
`ifdef PCU_EXCEPTION_EN
    chk({tag, ".epc"},   epc_out, m_epc);
`endif
  endtask

  initial begin
    // reset, then INC x3
    vecs.push_back(mk(1, 1, PCU_INC,  8'h00, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_INC,  8'h00, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_INC,  8'h00, 8'h00, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_INC,  8'h00, 8'h00, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 0, PCU_JUMP, 8'h55, 8'h00, 8'h03, 0, 0, 0));
    // wrap-around and negative branch
    vecs.push_back(mk(0, 1, PCU_JUMP,   8'hFE, 8'h00, 8'hFE, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_INC,    8'h00, 8'h00, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_INC,    8'h00, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_BRANCH, 8'h00, 8'hFC, 8'hFC, 0, 0, 0));
    // reserved codes hold
    vecs.push_back(mk(0, 1, 3'd6, 8'h77, 8'h05, 8'hFC, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd7, 8'h77, 8'h05, 8'hFC, 0, 0, 0));
    // nested call/return
    vecs.push_back(mk(0, 1, PCU_JUMP, 8'h10, 8'h00, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h40, 8'h00, 8'h40, 1, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h80, 8'h00, 8'h80, 2, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h41, 1, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h11, 0, 0, 0));
    // overflow then underflow
    vecs.push_back(mk(1, 0, PCU_HOLD, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h01, 8'h00, 8'h01, 1, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h02, 8'h00, 8'h02, 2, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h03, 8'h00, 8'h03, 3, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h04, 8'h00, 8'h04, 4, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h05, 8'h00, 8'h05, 4, 1, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h05, 3, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h04, 2, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h03, 1, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h03, 0, 0, 1));
    vecs.push_back(mk(0, 0, PCU_RET,  8'h00, 8'h00, 8'h03, 0, 0, 0));
    // reset in the middle of a call sequence
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h20, 8'h00, 8'h20, 1, 0, 0));
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h30, 8'h00, 8'h30, 2, 0, 0));
    vecs.push_back(mk(1, 1, PCU_CALL, 8'h60, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h01, 0, 0, 1));
    // a call followed immediately by a return
    vecs.push_back(mk(0, 1, PCU_CALL, 8'h90, 8'h00, 8'h90, 1, 0, 0));
    vecs.push_back(mk(0, 1, PCU_RET,  8'h00, 8'h00, 8'h02, 0, 0, 0));

    @(negedge clock);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pw, vecs[i].mode, vecs[i].tgt, vecs[i].off, 0);
      chk($sformatf("vec%0d.pc", i),    pc_out, vecs[i].pc);
      chk($sformatf("vec%0d.count", i), ras_count, vecs[i].cnt);
      chk($sformatf("vec%0d.empty", i), ras_empty, vecs[i].cnt == 0);
      chk($sformatf("vec%0d.full", i),  ras_full, vecs[i].cnt == DEPTH);
      chk($sformatf("vec%0d.ovf", i),   ras_overflow, vecs[i].ov);
      chk($sformatf("vec%0d.unf", i),   ras_underflow, vecs[i].un);
      chk($sformatf("vec%0d.model", i), pc_out, m_pc);
    end

`ifdef PCU_EXCEPTION_EN
    // An exception is taken even when pc_write is low, and it leaves the RAS untouched.
    drive(0, 1, PCU_CALL, 8'h22, 8'h00, 0);
    drive(0, 0, PCU_HOLD, 8'h00, 8'h00, 1);
    chk("exc.pc",    pc_out, 8'hF0);
    chk("exc.epc",   epc_out, 8'h22);
    chk("exc.count", ras_count, m_ras.size());
    drive(0, 1, PCU_HOLD, 8'h00, 8'h00, 0);
`endif

    // random run against the model
    for (int n = 0; n < 600; n++) begin
      bit rst, pw, exc;
      rst = ($urandom_range(0, 59) == 0);
      pw  = ($urandom_range(0, 7) != 0);
      exc = 0;
`ifdef PCU_EXCEPTION_EN
      exc = ($urandom_range(0, 29) == 0);
`endif
      drive(rst, pw, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), exc);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
